usb3_tx_skp_scheduler: RTL and testbench



---
 rtl/usb3_tx_pkg.sv | 14 +
 rtl/usb3_tx_skp_scheduler.sv | 121 ++++++++++++
 tb/tb_usb3_tx_skp_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/usb3_tx_pkg.sv
// Shared USB3 TX symbol constants and the SKP scheduler state type.
`timescale 1ns/1ps
package usb3_tx_pkg;

  localparam logic [7:0] K28_1_SKP = 8'h3C;
  localparam logic [7:0] K28_5_COM = 8'hBC;
  localparam logic [7:0] D_IDLE    = 8'h00;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_SKP  = 1'b1
  } skp_state_t;

endpackage

// File: rtl/usb3_tx_skp_scheduler.sv
// Merges link bytes, logical idle and periodic SKP ordered sets into the scrambler input; 1-cycle latency.
// s_ready depends only on registers and skp_en; it is low for the last pre-SKP symbol and for the whole SKP burst.
`timescale 1ns/1ps
module usb3_tx_skp_scheduler
  import usb3_tx_pkg::*;
#(
  parameter int SKP_INTERVAL = 354,  // legal 2..4095
  parameter int SKP_PAIRS    = 1     // legal 1..4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_k,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       skp_en,
  input  logic       scr_disable,
  output logic [7:0] sc_data,
  output logic       sc_valid,
  output logic       sc_is_control,
  output logic       sc_com,
  output logic       skp_active
);

  localparam int              CNT_W    = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [2:0]      SKP_LAST = 3'(2 * SKP_PAIRS - 1);

  skp_state_t       state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [2:0]       skp_cnt_q, skp_cnt_d;
  logic [7:0]       sc_data_q, sc_data_d;
  logic             sc_valid_q, sc_valid_d;
  logic             sc_is_control_q, sc_is_control_d;
  logic             sc_com_q, sc_com_d;
  logic             skp_active_q, skp_active_d;

  logic at_last;
  logic accept;

  // The last symbol before a SKP burst is always idle so the burst lands exactly on the interval.
  assign at_last = (sym_cnt_q == CNT_LAST);
  assign s_ready = (state_q == ST_DATA) && !(at_last && skp_en);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d         = state_q;
    sym_cnt_d       = sym_cnt_q;
    skp_cnt_d       = skp_cnt_q;
    sc_data_d       = D_IDLE;
    sc_is_control_d = 1'b0;
    skp_active_d    = 1'b0;
    sc_valid_d      = 1'b1;
    sc_com_d        = !scr_disable;

    unique case (state_q)
      ST_DATA: begin
        if (accept) begin
          sc_data_d       = s_data;
          sc_is_control_d = s_k;
        end
        if (!skp_en) begin
          sym_cnt_d = '0;
        end else if (at_last) begin
          sym_cnt_d = '0;
          skp_cnt_d = '0;
          state_d   = ST_SKP;
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
      ST_SKP: begin
        // A started burst always completes, regardless of skp_en.
        sc_data_d       = K28_1_SKP;
        sc_is_control_d = 1'b1;
        skp_active_d    = 1'b1;
        sym_cnt_d       = '0;
        if (skp_cnt_q == SKP_LAST) begin
          skp_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          skp_cnt_d = skp_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_DATA;
        sym_cnt_d = '0;
        skp_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_DATA;
      sym_cnt_q       <= '0;
      skp_cnt_q       <= '0;
      sc_data_q       <= D_IDLE;
      sc_valid_q      <= 1'b0;
      sc_is_control_q <= 1'b0;
      sc_com_q        <= 1'b0;
      skp_active_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      sym_cnt_q       <= sym_cnt_d;
      skp_cnt_q       <= skp_cnt_d;
      sc_data_q       <= sc_data_d;
      sc_valid_q      <= sc_valid_d;
      sc_is_control_q <= sc_is_control_d;
      sc_com_q        <= sc_com_d;
      skp_active_q    <= skp_active_d;
    end
  end

  assign sc_data       = sc_data_q;
  assign sc_valid      = sc_valid_q;
  assign sc_is_control = sc_is_control_q;
  assign sc_com        = sc_com_q;
  assign skp_active    = skp_active_q;

endmodule

// File: tb/tb_usb3_tx_skp_scheduler.sv
// Directed and randomized bench for usb3_tx_skp_scheduler against a symbol-level reference model.
`timescale 1ns/1ps
module tb_usb3_tx_skp_scheduler;

  localparam int INT    = 8;
  localparam int PAIRS  = 1;
  localparam int PAIRS2 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_k, s_valid, s_ready, skp_en, scr_disable;
  logic [7:0] sc_data;
  logic       sc_valid, sc_is_control, sc_com, skp_active;

  logic [7:0] sc_data2;
  logic       s_ready2, sc_valid2, sc_is_control2, sc_com2, skp_active2;

  always #5 clk = ~clk;

  usb3_tx_skp_scheduler #(.SKP_INTERVAL(INT), .SKP_PAIRS(PAIRS)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_k(s_k), .s_valid(s_valid),
    .s_ready(s_ready), .skp_en(skp_en), .scr_disable(scr_disable),
    .sc_data(sc_data), .sc_valid(sc_valid), .sc_is_control(sc_is_control),
    .sc_com(sc_com), .skp_active(skp_active)
  );

  // Idle-only instance with two SKP pairs per insertion.
  usb3_tx_skp_scheduler #(.SKP_INTERVAL(INT), .SKP_PAIRS(PAIRS2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(8'h00), .s_k(1'b0), .s_valid(1'b0),
    .s_ready(s_ready2), .skp_en(1'b1), .scr_disable(1'b0),
    .sc_data(sc_data2), .sc_valid(sc_valid2), .sc_is_control(sc_is_control2),
    .sc_com(sc_com2), .skp_active(skp_active2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: symbols since the last SKP burst, and SKP symbols still owed.
  bit         m_skp;
  int         m_left;
  int         m_run;
  logic [7:0] e_data;
  logic       e_valid, e_ctl, e_com, e_act;
  int         g2, r2, runs2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_skp = 1'b0; m_left = 0; m_run = 0;
    e_data = 8'h00; e_valid = 1'b0; e_ctl = 1'b0; e_com = 1'b0; e_act = 1'b0;
    g2 = 0; r2 = 0;
  endtask

  task automatic check_outs();
    chk("sc_valid",      32'(sc_valid),      32'(e_valid));
    chk("sc_data",       32'(sc_data),       32'(e_data));
    chk("sc_is_control", 32'(sc_is_control), 32'(e_ctl));
    chk("sc_com",        32'(sc_com),        32'(e_com));
    chk("skp_active",    32'(skp_active),    32'(e_act));
  endtask

  // Interval and burst length on the two-pair instance, measured in valid symbols.
  task automatic watch2();
    if (sc_valid2) begin
      if (sc_data2 == 8'h3C) begin
        if (r2 == 0) begin
          chk("gap2", 32'(g2), 32'(INT));
          g2 = 0;
        end
        r2++;
      end else begin
        if (r2 > 0) begin
          chk("run2", 32'(r2), 32'(2 * PAIRS2));
          runs2++;
          r2 = 0;
        end
        g2++;
      end
    end
  endtask

  task automatic step(input bit v, input bit en, input bit sd, input bit k,
                      input logic [7:0] d, output bit acc);
    bit rdy;
    s_valid = v; skp_en = en; scr_disable = sd; s_k = k; s_data = d;
    #1;
    rdy = !m_skp && !(en && m_run == INT - 1);
    chk("s_ready", 32'(s_ready), 32'(rdy));
    acc = v && rdy;
    e_valid = 1'b1;
    e_com   = !sd;
    if (m_skp) begin
      e_data = 8'h3C; e_ctl = 1'b1; e_act = 1'b1;
      m_left--;
      if (m_left == 0) m_skp = 1'b0;
    end else begin
      e_act  = 1'b0;
      e_data = acc ? d : 8'h00;
      e_ctl  = acc ? k : 1'b0;
      if (!en) m_run = 0;
      else if (m_run == INT - 1) begin
        m_run = 0; m_skp = 1'b1; m_left = 2 * PAIRS;
      end else m_run++;
    end
    @(negedge clk);
    check_outs();
    watch2();
  endtask

  initial begin
    bit         acc;
    bit         hit;
    logic [7:0] b;

    rst_n = 1'b0; s_valid = 1'b0; s_k = 1'b0; s_data = 8'h00;
    skp_en = 1'b0; scr_disable = 1'b0;
    model_reset();
    runs2 = 0;

    #12;
    check_outs();
    chk("s_ready_in_reset", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle only, insertion disabled.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h55, acc);

    // Continuous incrementing bytes with insertion enabled.
    b = 8'h01;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, b, acc);
      if (acc) b++;
    end

    // Drop skp_en on the second SKP symbol; the burst must still complete.
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_skp && m_left == 1) hit = 1'b1;
      else begin
        step(1'b1, 1'b1, 1'b0, 1'b0, b, acc);
        if (acc) b++;
      end
    end
    chk("reach_second_skp", 32'(hit), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 8'($urandom), acc);
      if (i == 0 || i == 19) chk("sym_cnt_held", 32'(u_dut.sym_cnt_q), 32'd0);
    end

    // Unscrambled transmission window, then back to scrambled.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'($urandom), acc);
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom), acc);

    // Asynchronous reset in the middle of a SKP burst.
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom), acc);
      if (e_act) hit = 1'b1;
    end
    chk("reach_skp_for_reset", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("s_ready_mid_reset", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom), acc);

    // Randomized traffic, enables and control bytes.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           8'($urandom), acc);
    end

    chk("two_pair_bursts_seen", 32'(runs2 >= 3), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
